// File: rtl/schmitt_debounce_pkg.sv
// schmitt_debounce_pkg: shared defaults and state encoding for the debounced Schmitt channels
package schmitt_debounce_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_CNT_MAX = 255;
  localparam int DEF_HI_TH = 200;
  localparam int DEF_LO_TH = 55;
  localparam int DEF_SYNC_STAGES = 2;
  typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_e;
endpackage

// File: rtl/schmitt_debounce_chan.sv
// schmitt_debounce_chan: one channel of synchronizer, saturating integrator, hysteresis state and edge strobes
module schmitt_debounce_chan
  import schmitt_debounce_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int CNT_MAX = DEF_CNT_MAX,
  parameter int HI_TH = DEF_HI_TH,
  parameter int LO_TH = DEF_LO_TH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout_n,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_TH);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic s;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    s = sync_q[SYNC_STAGES-1];
    cnt_d = (s && cnt_q < MAX_C) ? cnt_q + 1'b1 : (!s && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // thresholds act on the registered count, so state lags the counter by one edge
    state_d = (state_q == ST_LOW && cnt_q >= HI_C) ? ST_HIGH :
              (state_q == ST_HIGH && cnt_q <= LO_C) ? ST_LOW : state_q;
    rise_d = state_q == ST_LOW && state_d == ST_HIGH;
    fall_d = state_q == ST_HIGH && state_d == ST_LOW;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      state_q <= ST_LOW;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign dout_n = state_q == ST_LOW;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/schmitt_debounce_hex.sv
// schmitt_debounce_hex: CHANNELS independent debounced, inverted Schmitt-style input conditioners
module schmitt_debounce_hex
  import schmitt_debounce_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CNT_MAX = DEF_CNT_MAX,
  parameter int HI_TH = DEF_HI_TH,
  parameter int LO_TH = DEF_LO_TH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout_n,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);
  if (!(LO_TH >= 0 && LO_TH < HI_TH && HI_TH <= CNT_MAX && CNT_MAX <= 2**CNT_W - 1 && SYNC_STAGES >= 2))
    begin : g_bad_params
      $error("schmitt_debounce_hex: illegal threshold, width or sync-stage parameters");
    end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    schmitt_debounce_chan #(
      .CNT_W(CNT_W),
      .CNT_MAX(CNT_MAX),
      .HI_TH(HI_TH),
      .LO_TH(LO_TH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .din(din[g]),
      .dout_n(dout_n[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end
endmodule

// File: tb/tb_schmitt_debounce_hex.sv
// tb_schmitt_debounce_hex: table vectors, hand corner sequences and random stimulus against a reference model
module tb_schmitt_debounce_hex;
  localparam int CH = 6, CW = 4, CM = 15, HI = 12, LO = 3, SS = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [CH-1:0] din = '0, dout_n, rise, fall;
  int errors = 0, checks = 0;
  int m_cnt[CH];
  bit m_state[CH];
  logic [CH-1:0] m_rise, m_fall, rise_seen, fall_seen;
  logic [CH-1:0] hist[$];
  typedef struct {logic [CH-1:0] din; int n; logic [CH-1:0] dout_n, rise_seen, fall_seen;} vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  schmitt_debounce_hex #(.CHANNELS(CH), .CNT_W(CW), .CNT_MAX(CM), .HI_TH(HI), .LO_TH(LO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .din(din), .dout_n(dout_n), .rise(rise), .fall(fall));

  function automatic void model_reset();
    hist.delete();
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_state[c] = 1'b0;
    end
  endfunction

  // input word seen by the integrator at this edge is the one sampled SS edges earlier
  function automatic void model_step(logic [CH-1:0] d);
    logic [CH-1:0] s;
    int old;
    bit ns;
    s = (hist.size() >= SS) ? hist[hist.size() - SS] : '0;
    hist.push_back(d);
    if (hist.size() > SS) void'(hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      old = m_cnt[c];
      ns = (old >= HI) ? 1'b1 : (old <= LO) ? 1'b0 : m_state[c];
      m_rise[c] = ns && !m_state[c];
      m_fall[c] = !ns && m_state[c];
      m_state[c] = ns;
      m_cnt[c] = old + (s[c] ? 1 : -1);
      if (m_cnt[c] > CM) m_cnt[c] = CM;
      if (m_cnt[c] < 0) m_cnt[c] = 0;
    end
  endfunction

  function automatic logic [CH-1:0] model_dout();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = !m_state[c];
    return r;
  endfunction

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [CH-1:0] d;
    d = din;
    @(posedge clk);
    #1;
    model_step(d);
    check("model_dout_n", dout_n, model_dout());
    check("model_rise", rise, m_rise);
    check("model_fall", fall, m_fall);
    check("rise_fall_exclusive", rise & fall, '0);
    rise_seen |= rise;
    fall_seen |= fall;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_dout_n", dout_n, '1);
    check("reset_rise", rise, '0);
    check("reset_fall", fall, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{6'h00, 40, 6'h3F, 6'h00, 6'h00};
    tbl[1] = '{6'h01, 14, 6'h3F, 6'h00, 6'h00};
    tbl[2] = '{6'h01, 1, 6'h3E, 6'h01, 6'h00};
    tbl[3] = '{6'h01, 20, 6'h3E, 6'h00, 6'h00};
    tbl[4] = '{6'h00, 14, 6'h3E, 6'h00, 6'h00};
    tbl[5] = '{6'h00, 1, 6'h3F, 6'h00, 6'h01};
    tbl[6] = '{6'h02, 5, 6'h3F, 6'h00, 6'h00};
    tbl[7] = '{6'h00, 30, 6'h3F, 6'h00, 6'h00};
    tbl[8] = '{6'h14, 14, 6'h3F, 6'h00, 6'h00};
    tbl[9] = '{6'h14, 1, 6'h2B, 6'h14, 6'h00};
    model_reset();
    #3;
    check("por_dout_n", dout_n, 6'h3F);
    check("por_rise", rise, '0);
    check("por_fall", fall, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = tbl[i].din;
      rise_seen = '0;
      fall_seen = '0;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d_dout_n", i), dout_n, tbl[i].dout_n);
      check($sformatf("vec%0d_rise_seen", i), rise_seen, tbl[i].rise_seen);
      check($sformatf("vec%0d_fall_seen", i), fall_seen, tbl[i].fall_seen);
    end
    // hysteresis: count rises past HI_TH, then 3-low/2-high chatter keeps it between thresholds
    rise_seen = '0;
    fall_seen = '0;
    din = 6'h08;
    repeat (13) tick();
    for (int p = 0; p < 5; p++) begin
      din = 6'h00;
      repeat (3) tick();
      din = 6'h08;
      repeat (2) tick();
    end
    check("hyst_dout_n", dout_n, 6'h37);
    check("hyst_rise3", {5'b0, rise_seen[3]}, 6'h01);
    check("hyst_fall3", {5'b0, fall_seen[3]}, 6'h00);
    din = 6'h20;
    repeat (10) tick();
    reset_mid_cycle();
    rise_seen = '0;
    repeat (14) tick();
    check("post_reset_hold_dout_n", dout_n, 6'h3F);
    check("post_reset_hold_rise", rise_seen, 6'h00);
    tick();
    check("post_reset_rise_dout_n", dout_n, 6'h1F);
    check("post_reset_rise", rise, 6'h20);
    for (int b = 0; b < 8; b++) begin
      int p;
      p = $urandom_range(1, 30);
      for (int t = 0; t < 200; t++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, p - 1) == 0) din[c] = ~din[c];
        tick();
      end
      if (b % 3 == 2) reset_mid_cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/schmitt_debounce_hex.md
Name: schmitt_debounce_hex

Overview:
- Sequential counterpart to the hex Schmitt inverter emulation.
- The discrete board conditions noisy switch, reset and single-step inputs with RC plus Schmitt inverters. On the FPGA those inputs arrive as raw, bouncy, asynchronous pins, so this block does that conditioning digitally.
- Six independent channels, each with a synchronizer, a saturating integrator and hysteresis thresholds.
- Output polarity is inverted, matching the '14. Per-channel edge strobes are added for the step/clock logic.

Parameters:
- CHANNELS, 6: number of independent channels.
- CNT_W, 8: integrator counter width.
- CNT_MAX, 255: saturation value; must be ≤ 2^CNT_W-1.
- HI_TH, 200: the integrator must reach this value (≥) for the state to go high.
- LO_TH, 55: the integrator must fall to this value (≤) for the state to go low. Requires 0 ≤ LO_TH < HI_TH ≤ CNT_MAX.
- SYNC_STAGES, 2: synchronizer flops per channel; must be ≥ 2.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  CHANNELS  raw asynchronous inputs, one bit per channel.
- dout_n  out  CHANNELS  conditioned, inverted output (Schmitt-inverter equivalent).
- rise  out  CHANNELS  1-cycle pulse when the channel's internal state goes 0→1, i.e. dout_n falls.
- fall  out  CHANNELS  1-cycle pulse when the channel's internal state goes 1→0, i.e. dout_n rises.

Behaviour:
- Reset values (asynchronous, immediate):
  - sync chain = 0, counter = 0, state = 0.
  - dout_n = all 1s, rise = 0, fall = 0.
- Synchronizer:
  - din[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
  - No combinational path from din to any output.
- Integrator, per channel, registered:
  - If s=1 and cnt<CNT_MAX: cnt+1.
  - If s=0 and cnt>0: cnt-1.
  - Otherwise hold. Saturates at both ends; never wraps.
- State machine, two states LOW/HIGH, next state decided from the current registered cnt:
  - LOW→HIGH when cnt ≥ HI_TH.
  - HIGH→LOW when cnt ≤ LO_TH.
  - Otherwise hold. For LO_TH < cnt < HI_TH the previous state is kept (hysteresis).
- dout_n[i] = ~state[i], driven directly from the state register.
- rise/fall are registered and asserted in the same cycle that state takes its new value. They are never both high on one channel. Channels are fully independent, so simultaneous edges on different channels are allowed.
- Latency, from a clean step on din with cnt at the opposite rail:
  - Rising, cnt=0: state/dout_n change at edge SYNC_STAGES+HI_TH+1.
  - Falling, cnt=CNT_MAX: change at edge SYNC_STAGES+(CNT_MAX-LO_TH)+1.
- Glitches: a pulse shorter than HI_TH-cnt cycles never changes state.
- Continuous chatter with duty ~50%: cnt wanders, and state changes only on crossing the thresholds.
- Reset mid-operation: all channels return to reset values immediately, with no pulses emitted. After release, a steady high input needs the full rising latency.

Decomposition:
- Package schmitt_debounce_pkg:
  - Default constants for CNT_W, CNT_MAX, HI_TH, LO_TH, SYNC_STAGES.
  - State encoding constants ST_LOW=0, ST_HIGH=1.
- Sub-module schmitt_debounce_chan holds one channel: synchronizer, counter, state, pulses. The top generates CHANNELS instances and concatenates the outputs.
- Elaboration-time parameter check: LO_TH < HI_TH ≤ CNT_MAX, SYNC_STAGES ≥ 2.

Test Plan:
(Bench uses CNT_W=4, CNT_MAX=15, HI_TH=12, LO_TH=3, SYNC_STAGES=2.)
- Reset then steady state: assert rst mid-cycle → dout_n=6'b111111 immediately, rise=fall=0; release with din=0 for 40 cycles → outputs unchanged.
- Clean rise: din[0] 0→1 before edge 0 → dout_n[0] falls and rise[0]=1 for exactly one cycle at edge 15; other channels unchanged.
- Clean fall: after saturating at 15, din[0] 1→0 → dout_n[0] rises and fall[0] pulses at edge 2+12+1=15.
- Glitch rejection: din[1] high for 5 cycles then low → cnt peaks at 5, no rise, dout_n[1] stays 1.
- Hysteresis: drive cnt to 13 (state HIGH), then alternate din 3 low/2 high → cnt hovers at 6–13, state holds HIGH, no pulses.
- Independence plus reset mid-op: rise din[2] and din[4] together → both rise pulses on the same edge; assert rst at cnt=8 → all counters 0; after release the full 15-edge latency is required again.
